// File: rtl/full_adder_pkg.sv
// ============================================================================
// full_adder_pkg : shared constants for the registered ripple-carry adder
// Revision 1.0
// ============================================================================
`default_nettype none

package full_adder_pkg;

    localparam int ADDER_WIDTH_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/full_adder_bit.sv
// ============================================================================
// full_adder_bit : one-bit combinational full adder cell
// Revision 1.0
// ============================================================================
`default_nettype none

module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic prop;

    assign prop = a ^ b;
    assign s    = prop ^ ci;
    assign co   = (a & b) | (ci & prop);

endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// full_adder : WIDTH-bit ripple-carry adder with registered sum/cout/overflow
// Revision 1.0
// ============================================================================
`default_nettype none

module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            full_adder_bit u_bit (
                .a  (a[i]),
                .b  (b[i]),
                .ci (carry[i]),
                .s  (sum_comb[i]),
                .co (carry[i+1])
            );
        end
    endgenerate

    // Result registers load only on accepted operands, so idle-cycle X never reaches them.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum      <= sum_comb;
                cout     <= carry[WIDTH];
                overflow <= carry[WIDTH] ^ carry[WIDTH-1];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_full_adder.sv
// ============================================================================
// tb_full_adder : scoreboard bench for full_adder at WIDTH=4
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_full_adder;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         out_valid;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t last_res = '0;

    full_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference model: arithmetic add plus sign-rule overflow.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        exp_t       e;
        logic [W:0] full;
        full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        e.s  = full[W-1:0];
        e.co = full[W];
        e.ov = (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]);
        return e;
    endfunction

    // Drive one cycle of stimulus, then check the registered outputs after the edge.
    task automatic step(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        a        = ta;
        b        = tb;
        cin      = tc;
        if (v && !rst) exp_q.push_back(model(ta, tb, tc));
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_value("out_valid", {31'b0, out_valid}, 32'd1);
            check_value("sum", {28'b0, sum}, {28'b0, e.s});
            check_value("cout", {31'b0, cout}, {31'b0, e.co});
            check_value("overflow", {31'b0, overflow}, {31'b0, e.ov});
            last_res = e;
        end else begin
            check_value("idle_out_valid", {31'b0, out_valid}, 32'd0);
            check_value("hold_sum", {28'b0, sum}, {28'b0, last_res.s});
            check_value("hold_cout", {31'b0, cout}, {31'b0, last_res.co});
            check_value("hold_overflow", {31'b0, overflow}, {31'b0, last_res.ov});
        end
    endtask

    initial begin
        // Reset with live operands: reset must win.
        rst = 1'b1;
        step(1'b1, 4'hF, 4'hF, 1'b1);
        step(1'b1, 4'hF, 4'hF, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Directed sums
        step(1'b1, 4'd1, 4'd2, 1'b1);
        step(1'b1, 4'd1, 4'd2, 1'b0);
        step(1'b1, 4'd4, 4'd1, 1'b1);
        step(1'b1, 4'd4, 4'd1, 1'b0);
        step(1'b1, 4'd12, 4'd0, 1'b1);
        step(1'b1, 4'd12, 4'd0, 1'b0);

        // Carry / wrap and signed overflow
        step(1'b1, 4'd15, 4'd0, 1'b1);
        step(1'b1, 4'd15, 4'd15, 1'b1);
        step(1'b1, 4'd7, 4'd1, 1'b0);
        step(1'b1, 4'd8, 4'd8, 1'b0);

        // Hold and bubble, with unknown operands while idle
        step(1'b1, 4'd3, 4'd4, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 'x, 'x, 1'bx);
        step(1'b1, 4'd2, 4'd2, 1'b0);

        // Exhaustive back-to-back sweep
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            step(1'b1, v[8:5], v[4:1], v[0]);
        end

        step(1'b0, 4'd0, 4'd0, 1'b0);
        check_value("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
